// File: rtl/uart_byte_stream.sv
// Full-duplex 8N1 UART between the PC serial pins and the picture-transfer byte stream.
// Optional build macro UART_FRAMING_CHECK_EN: drop bytes with a bad stop bit and pulse rx_frame_err.
module uart_byte_stream #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic       txd,
    output logic [7:0] data_stream_rx,
    output logic       data_stream_rx_stb,
    input  logic [7:0] data_stream_tx,
    input  logic       data_stream_tx_stb,
    output logic       data_stream_tx_ack,
    output logic       rx_frame_err
);
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    // ---------------- receive ----------------
    logic            rx_meta_reg, rx_sync_reg, rx_prev_reg;
    rx_state_t       rx_state_reg, rx_state_next;
    logic [CW-1:0]   rx_cnt_reg, rx_cnt_next;
    logic [2:0]      rx_idx_reg, rx_idx_next;
    logic [7:0]      rx_shift_reg, rx_shift_next;
    logic [7:0]      rx_data_reg, rx_data_next;
    logic            rx_stb_reg, rx_stb_next;
`ifdef UART_FRAMING_CHECK_EN
    logic            frame_err_reg, frame_err_next;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_reg   <= 1'b1;
            rx_sync_reg   <= 1'b1;
            rx_prev_reg   <= 1'b1;
            rx_state_reg  <= RX_IDLE;
            rx_cnt_reg    <= '0;
            rx_idx_reg    <= '0;
            rx_shift_reg  <= '0;
            rx_data_reg   <= '0;
            rx_stb_reg    <= 1'b0;
`ifdef UART_FRAMING_CHECK_EN
            frame_err_reg <= 1'b0;
`endif
        end else begin
            rx_meta_reg   <= rxd;
            rx_sync_reg   <= rx_meta_reg;
            rx_prev_reg   <= rx_sync_reg;
            rx_state_reg  <= rx_state_next;
            rx_cnt_reg    <= rx_cnt_next;
            rx_idx_reg    <= rx_idx_next;
            rx_shift_reg  <= rx_shift_next;
            rx_data_reg   <= rx_data_next;
            rx_stb_reg    <= rx_stb_next;
`ifdef UART_FRAMING_CHECK_EN
            frame_err_reg <= frame_err_next;
`endif
        end
    end

    always_comb begin
        rx_state_next  = rx_state_reg;
        rx_cnt_next    = rx_cnt_reg;
        rx_idx_next    = rx_idx_reg;
        rx_shift_next  = rx_shift_reg;
        rx_data_next   = rx_data_reg;
        rx_stb_next    = 1'b0;
`ifdef UART_FRAMING_CHECK_EN
        frame_err_next = 1'b0;
`endif
        unique case (rx_state_reg)
            RX_IDLE: begin
                rx_cnt_next = '0;
                if (rx_prev_reg && !rx_sync_reg)
                    rx_state_next = RX_START;
            end
            RX_START: begin
                if (rx_cnt_reg == HALF_LAST) begin
                    // Mid-start-bit re-check rejects short glitches on the line.
                    rx_cnt_next   = '0;
                    rx_idx_next   = '0;
                    rx_state_next = rx_sync_reg ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_next = rx_cnt_reg + CNT_ONE;
                end
            end
            RX_DATA: begin
                if (rx_cnt_reg == BIT_LAST) begin
                    rx_cnt_next   = '0;
                    rx_shift_next = {rx_sync_reg, rx_shift_reg[7:1]};
                    rx_idx_next   = rx_idx_reg + 3'd1;
                    if (rx_idx_reg == 3'd7)
                        rx_state_next = RX_STOP;
                end else begin
                    rx_cnt_next = rx_cnt_reg + CNT_ONE;
                end
            end
            RX_STOP: begin
                if (rx_cnt_reg == BIT_LAST) begin
                    rx_cnt_next = '0;
                    if (rx_sync_reg) begin
                        rx_data_next  = rx_shift_reg;
                        rx_stb_next   = 1'b1;
                        rx_state_next = RX_IDLE;
                    end else begin
`ifdef UART_FRAMING_CHECK_EN
                        frame_err_next = 1'b1;
`else
                        rx_data_next   = rx_shift_reg;
                        rx_stb_next    = 1'b1;
`endif
                        rx_state_next  = RX_BREAK;
                    end
                end else begin
                    rx_cnt_next = rx_cnt_reg + CNT_ONE;
                end
            end
            RX_BREAK: begin
                // A line held low must go high again before a new start bit counts.
                if (rx_sync_reg)
                    rx_state_next = RX_IDLE;
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    assign data_stream_rx     = rx_data_reg;
    assign data_stream_rx_stb = rx_stb_reg;
`ifdef UART_FRAMING_CHECK_EN
    assign rx_frame_err = frame_err_reg;
`else
    assign rx_frame_err = 1'b0;
`endif

    // ---------------- transmit ----------------
    tx_state_t       tx_state_reg, tx_state_next;
    logic [CW-1:0]   tx_cnt_reg, tx_cnt_next;
    logic [2:0]      tx_idx_reg, tx_idx_next;
    logic [7:0]      tx_shift_reg, tx_shift_next;
    logic            txd_reg, txd_next;
    logic            tx_ack_reg, tx_ack_next;
    logic            tx_load;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_reg <= TX_IDLE;
            tx_cnt_reg   <= '0;
            tx_idx_reg   <= '0;
            tx_shift_reg <= '0;
            txd_reg      <= 1'b1;
            tx_ack_reg   <= 1'b0;
        end else begin
            tx_state_reg <= tx_state_next;
            tx_cnt_reg   <= tx_cnt_next;
            tx_idx_reg   <= tx_idx_next;
            tx_shift_reg <= tx_shift_next;
            txd_reg      <= txd_next;
            tx_ack_reg   <= tx_ack_next;
        end
    end

    always_comb begin
        tx_state_next = tx_state_reg;
        tx_cnt_next   = tx_cnt_reg;
        tx_idx_next   = tx_idx_reg;
        tx_shift_next = tx_shift_reg;
        txd_next      = txd_reg;
        tx_ack_next   = 1'b0;
        tx_load       = 1'b0;
        unique case (tx_state_reg)
            TX_IDLE: tx_load = data_stream_tx_stb;
            TX_START: begin
                if (tx_cnt_reg == BIT_LAST) begin
                    tx_cnt_next   = '0;
                    tx_idx_next   = '0;
                    txd_next      = tx_shift_reg[0];
                    tx_shift_next = {1'b0, tx_shift_reg[7:1]};
                    tx_state_next = TX_DATA;
                end else begin
                    tx_cnt_next = tx_cnt_reg + CNT_ONE;
                end
            end
            TX_DATA: begin
                if (tx_cnt_reg == BIT_LAST) begin
                    tx_cnt_next = '0;
                    if (tx_idx_reg == 3'd7) begin
                        txd_next      = 1'b1;
                        tx_state_next = TX_STOP;
                    end else begin
                        txd_next      = tx_shift_reg[0];
                        tx_shift_next = {1'b0, tx_shift_reg[7:1]};
                        tx_idx_next   = tx_idx_reg + 3'd1;
                    end
                end else begin
                    tx_cnt_next = tx_cnt_reg + CNT_ONE;
                end
            end
            TX_STOP: begin
                // The last stop cycle doubles as the idle slot so streamed bytes have no gap.
                if (tx_cnt_reg == BIT_LAST) begin
                    tx_cnt_next   = '0;
                    tx_state_next = TX_IDLE;
                    tx_load       = data_stream_tx_stb;
                end else begin
                    tx_cnt_next = tx_cnt_reg + CNT_ONE;
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase
        if (tx_load) begin
            tx_shift_next = data_stream_tx;
            tx_ack_next   = 1'b1;
            txd_next      = 1'b0;
            tx_cnt_next   = '0;
            tx_state_next = TX_START;
        end
    end

    assign txd                = txd_reg;
    assign data_stream_tx_ack = tx_ack_reg;

endmodule

// File: doc/uart_byte_stream.md
# uart_byte_stream

Full-duplex 8N1 UART serialiser/deserialiser that sits directly upstream of the picture-transfer controller. It converts the PC serial line into the controller's byte stream: received bytes arrive as a one-cycle strobe, and transmit bytes use a strobe/acknowledge handshake. One instance per board, between the pin pads and the controller.

## Interface
- CLKS_PER_BIT, default 868: clock cycles per serial bit (100 MHz / 115200 baud); legal range 4..65535.
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- rxd  in  1  serial receive line from PC, asynchronous, idle high.
- txd  out  1  serial transmit line to PC, idle high.
- data_stream_rx  out  8  last received byte.
- data_stream_rx_stb  out  1  one-cycle pulse: data_stream_rx holds a new byte.
- data_stream_tx  in  8  byte to send; must be held stable while data_stream_tx_stb=1.
- data_stream_tx_stb  in  1  transmit request, held high until acknowledged.
- data_stream_tx_ack  out  1  one-cycle pulse: byte accepted.
- rx_frame_err  out  1  one-cycle pulse: stop bit sampled low.

## Operation
- Frame format: start bit (0), 8 data bits LSB first, stop bit (1); every bit lasts CLKS_PER_BIT cycles.
- Reset values: txd=1, data_stream_rx=0, data_stream_rx_stb=0, data_stream_tx_ack=0, rx_frame_err=0. Both synchroniser flops reset to 1, and both FSMs reset to IDLE.
- The bit counter width is $clog2(CLKS_PER_BIT). The bit index is 3 bits. Counters reload and never wrap freely.
- rxd passes through a 2-flop synchroniser. Every rx decision uses the synchronised value.
- RX FSM:
  - RX_IDLE → RX_START on a synced 1→0 transition.
  - RX_START: wait CLKS_PER_BIT/2 cycles, then sample. If the sample is 1 (glitch), return to RX_IDLE with no output. If it is 0, go to RX_DATA.
  - RX_DATA: sample every CLKS_PER_BIT cycles and shift the bit into the shift register MSB (LSB-first reception). After 8 samples go to RX_STOP.
  - RX_STOP: sample after CLKS_PER_BIT cycles.
    - Sample 1: load data_stream_rx, pulse data_stream_rx_stb, go to RX_IDLE.
    - Sample 0: handled per Configuration, then go to RX_BREAK.
  - RX_BREAK: wait for synced rxd=1, then go to RX_IDLE. This prevents a held-low line from retriggering.
- TX FSM:
  - TX_IDLE: if data_stream_tx_stb=1, latch data_stream_tx, pulse data_stream_tx_ack, drive txd=0, go to TX_START.
  - TX_START → TX_DATA (8 bits, LSB first) → TX_STOP (txd=1) → TX_IDLE. Each state lasts CLKS_PER_BIT cycles per bit.
- The ack pulses only from TX_IDLE. While busy, a held stb is ignored and is served when the FSM returns to TX_IDLE.
- Simultaneous events: RX and TX are fully independent. An rx_stb and a tx_ack may occur in the same cycle.
- Reset mid-frame: both FSMs abort immediately and txd goes to 1. A partial rx byte is discarded and no stb is emitted.

## Timing
- tx_ack is registered. It goes high the cycle after the first clk edge at which stb=1 is seen in TX_IDLE, stays high for exactly 1 cycle, and coincides with txd first going 0.
- The TX frame occupies exactly 10·CLKS_PER_BIT cycles from the txd falling edge. The earliest next ack is the first cycle after the stop bit ends. Back-to-back bytes therefore have zero idle gap.
- RX latency: rx_stb rises 3 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles after the rxd pad falling edge (±1 cycle for sampling phase).
- data_stream_rx is stable from the stb cycle until the next accepted byte.
- The consumer must sample data_stream_rx in the stb cycle. There is no buffering and no backpressure on RX.

## Configuration
- UART_FRAMING_CHECK_EN defined:
  - A stop bit sampled 0 drops the byte: no rx_stb, data_stream_rx unchanged.
  - rx_frame_err pulses for 1 cycle.
- UART_FRAMING_CHECK_EN undefined:
  - A stop bit sampled 0 still loads data_stream_rx and pulses rx_stb.
  - rx_frame_err is tied 0.
  - RX_BREAK is still entered in both builds.

## Test plan
- CLKS_PER_BIT=8, reset low then high. Drive an 8N1 frame 0x74 on rxd → exactly one rx_stb pulse with data_stream_rx=0x74, rx_frame_err=0, latency within ±1 cycle of 3+4+72.
- Hold tx_stb=1 with tx=0x79 → one ack pulse. txd shows 0, then 1,0,0,1,1,1,1,0, then 1, each bit 8 cycles, 80 cycles total; no second ack while stb is held during the frame.
- Stream 0x01, 0x02, 0x03, 0x04 by keeping stb high and changing data on each ack → acks spaced exactly 80 cycles apart, and the bytes appear on txd in order with no gap.
- 2-cycle low glitch on rxd → no rx_stb; a valid frame 0x55 immediately afterwards is received correctly.
- Frame 0xA5 with stop bit 0, then line held low for 30 cycles:
  - With UART_FRAMING_CHECK_EN: rx_frame_err pulses once, no rx_stb.
  - Without it: rx_stb with 0xA5.
  - In both builds, no further stb until the line returns high, then a valid frame 0x0F is received.
- Assert reset in the middle of an rx frame and a tx frame → txd=1 the same cycle. No stb or ack afterwards, and the next full frame in each direction is handled correctly.
